// File: rtl/ecb_cbc_chain_ctrl.sv
// ecb_cbc_chain_ctrl: ECB/CBC mode engine between the register file and the block-cipher core.
// Collects WORDS input words into one block, applies chaining, runs one core operation,
// then returns the result MSW first. Only one block is in flight at any time.
// Optional feature: define ECB_CBC_BLKCNT_EN to add the blk_cnt completed-block counter port.
module ecb_cbc_chain_ctrl #(
   parameter int WORD_W      = 32,
   parameter int BLOCK_W     = 128,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               S_AXI_ACLK,
   input  logic               S_AXI_ARESET,
   input  logic               cfg_cbc,
   input  logic               cfg_dec,
   input  logic               iv_load,
   input  logic [BLOCK_W-1:0] iv,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_data,
   output logic               core_start,
   output logic               core_dec,
   output logic [BLOCK_W-1:0] core_din,
   input  logic               core_done,
   input  logic [BLOCK_W-1:0] core_dout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  out_data,
   output logic               busy,
`ifdef ECB_CBC_BLKCNT_EN
   output logic [31:0]        blk_cnt,
`endif
   output logic               err_timeout
);

   localparam int WORDS = BLOCK_W / WORD_W;
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {ST_COLLECT, ST_START, ST_WAIT, ST_EMIT} state_t;

   state_t             state_q;
   logic [CW-1:0]      word_cnt_q;
   logic [TW-1:0]      timer_q;
   logic [BLOCK_W-1:0] blk_q, chain_q, ct_save_q, res_q, core_din_q;
   logic               cbc_q, dec_q, core_start_q, in_ready_q, out_valid_q, err_q;
`ifdef ECB_CBC_BLKCNT_EN
   logic [31:0]        blk_cnt_q;
`endif

   logic               in_fire, out_fire, iv_ok, first_word, cbc_d, dec_d;
   logic [BLOCK_W-1:0] blk_d, chain_use, din_d;

   assign busy       = !(state_q == ST_COLLECT && word_cnt_q == '0);
   assign in_fire    = in_valid & in_ready_q;
   assign out_fire   = out_valid_q & out_ready;
   assign iv_ok      = iv_load & ~busy;
   assign first_word = (word_cnt_q == '0);
   // Mode is frozen on the first word of a block; later cfg changes wait for the next block.
   assign cbc_d      = first_word ? cfg_cbc : cbc_q;
   assign dec_d      = first_word ? cfg_dec : dec_q;
   // First word ends up in the most significant slot after WORDS shifts.
   assign blk_d      = (blk_q << WORD_W) | BLOCK_W'(in_data);
   // An iv_load coinciding with the first word must already apply to this block.
   assign chain_use  = iv_ok ? iv : chain_q;
   assign din_d      = (cbc_d && !dec_d) ? (blk_d ^ chain_use) : blk_d;

   assign in_ready    = in_ready_q;
   assign core_start  = core_start_q;
   assign core_dec    = dec_q;
   assign core_din    = core_din_q;
   assign out_valid   = out_valid_q;
   assign out_data    = res_q[BLOCK_W-1 -: WORD_W];
   assign err_timeout = err_q;
`ifdef ECB_CBC_BLKCNT_EN
   assign blk_cnt     = blk_cnt_q;
`endif

   // Mode FSM: collect -> start -> wait for core -> emit, with chaining and timeout handling.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state_q      <= ST_COLLECT;
         word_cnt_q   <= '0;
         timer_q      <= '0;
         blk_q        <= '0;
         chain_q      <= '0;
         ct_save_q    <= '0;
         res_q        <= '0;
         core_din_q   <= '0;
         cbc_q        <= 1'b0;
         dec_q        <= 1'b0;
         core_start_q <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         err_q        <= 1'b0;
`ifdef ECB_CBC_BLKCNT_EN
         blk_cnt_q    <= '0;
`endif
      end else begin
         core_start_q <= 1'b0;
         if (iv_ok) begin
            chain_q <= iv;
            err_q   <= 1'b0;
         end
         case (state_q)
            ST_COLLECT: begin
               in_ready_q <= 1'b1;
               if (in_fire) begin
                  blk_q <= blk_d;
                  cbc_q <= cbc_d;
                  dec_q <= dec_d;
                  if (word_cnt_q == CNT_LAST) begin
                     word_cnt_q   <= '0;
                     in_ready_q   <= 1'b0;
                     core_start_q <= 1'b1;
                     core_din_q   <= din_d;
                     if (cbc_d && dec_d) ct_save_q <= blk_d;
                     state_q      <= ST_START;
                  end else begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                  end
               end
            end
            ST_START: begin
               timer_q <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core_done) begin
                  timer_q     <= '0;
                  res_q       <= (cbc_q && dec_q) ? (core_dout ^ chain_q) : core_dout;
                  if (cbc_q) chain_q <= dec_q ? ct_save_q : core_dout;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_EMIT;
               end else if (timer_q == TMR_LAST) begin
                  // Core never answered: drop the block, keep the chain as it was.
                  timer_q    <= '0;
                  err_q      <= 1'b1;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_COLLECT;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            ST_EMIT: begin
               if (out_fire) begin
                  if (word_cnt_q == CNT_LAST) begin
                     word_cnt_q  <= '0;
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= ST_COLLECT;
`ifdef ECB_CBC_BLKCNT_EN
                     blk_cnt_q   <= blk_cnt_q + 32'd1;
`endif
                  end else begin
                     word_cnt_q <= word_cnt_q + 1'b1;
                     res_q      <= res_q << WORD_W;
                  end
               end
            end
            default: state_q <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_ecb_cbc_chain_ctrl.sv
// Directed bench for ecb_cbc_chain_ctrl with an XOR-based core model (done 12 cycles after start).
`timescale 1ns/1ps
module tb_ecb_cbc_chain_ctrl;
   localparam logic [127:0] K    = {4{32'hA5A5A5A5}};
   localparam logic [127:0] P    = {32'd1, 32'd2, 32'd3, 32'd4};
   localparam logic [127:0] IVA  = {4{32'h0000FFFF}};
   localparam logic [127:0] ECBP = {32'hA5A5A5A4, 32'hA5A5A5A7, 32'hA5A5A5A6, 32'hA5A5A5A1};
   localparam logic [127:0] C1   = {32'hA5A55A5B, 32'hA5A55A58, 32'hA5A55A59, 32'hA5A55A5E};
   localparam logic [127:0] C2   = {4{32'h0000FFFF}};

   logic         clk = 0, rst = 1;
   logic         cfg_cbc = 0, cfg_dec = 0, iv_load = 0;
   logic [127:0] iv = '0;
   logic         in_valid = 0, in_ready;
   logic [31:0]  in_data = '0;
   logic         core_start, core_dec, core_done = 0;
   logic [127:0] core_din, core_dout = '0;
   logic         out_valid, out_ready = 0;
   logic [31:0]  out_data;
   logic         busy, err_timeout;
`ifdef ECB_CBC_BLKCNT_EN
   logic [31:0]  blk_cnt;
`endif

   int n_chk = 0, n_err = 0;
   int start_cnt = 0, dcnt = 0;
   logic core_en = 1;
   logic [127:0] pend = '0;

   ecb_cbc_chain_ctrl dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .cfg_cbc(cfg_cbc), .cfg_dec(cfg_dec),
      .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_start(core_start), .core_dec(core_dec), .core_din(core_din),
      .core_done(core_done), .core_dout(core_dout), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy),
`ifdef ECB_CBC_BLKCNT_EN
      .blk_cnt(blk_cnt),
`endif
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Core model: answers 12 cycles after core_start with din ^ K.
   always @(negedge clk) begin
      core_done = 1'b0;
      if (dcnt > 0) begin
         dcnt = dcnt - 1;
         if (dcnt == 0) begin
            core_done = 1'b1;
            core_dout = pend ^ K;
         end
      end
      if (core_start) begin
         start_cnt = start_cnt + 1;
         if (core_en) begin
            dcnt = 12;
            pend = core_din;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_iv(input logic [127:0] v);
      @(negedge clk); iv = v; iv_load = 1;
      @(negedge clk); iv_load = 0;
   endtask

   // Send words lo..hi of block b; ld raises iv_load together with the first word.
   task automatic send_words(input logic [127:0] b, input int lo, input int hi, input logic ld);
      for (int i = lo; i <= hi; i++) begin
         int t = 0;
         @(negedge clk);
         in_valid = 1; in_data = b[127-32*i -: 32]; iv_load = ld && (i == lo);
         while (!in_ready && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) chk("in_ready_timeout", 0, 1);
         @(posedge clk);
      end
      @(negedge clk); in_valid = 0; iv_load = 0;
      if (hi == 3) chk("start_latency", core_start, 1);
   endtask

   task automatic recv_blk(output logic [127:0] r);
      r = '0;
      for (int i = 0; i < 4; i++) begin
         int t = 0;
         @(negedge clk); out_ready = 1;
         while (!out_valid && t < 300) begin @(negedge clk); t++; end
         if (t >= 300) chk("out_valid_timeout", 0, 1);
         r[127-32*i -: 32] = out_data;
         @(posedge clk);
      end
      @(negedge clk); out_ready = 0;
   endtask

   initial begin
      logic [127:0] r, d0;
      int t, s0;
      logic stable;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_din", core_din, 0);
      chk("rst_err", err_timeout, 0);
      rst = 0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);

      // ECB encrypt
      send_words(P, 0, 3, 0); recv_blk(r); chk("ecb_enc", r, ECBP);
      // CBC enc with no IV load: chain still zero after ECB, so result equals ECB
      cfg_cbc = 1; send_words(P, 0, 3, 0); recv_blk(r); chk("cbc_chain_zero", r, ECBP);
      // CBC enc, IV loaded with the first word, two chained blocks
      iv = IVA; send_words(P, 0, 3, 1); recv_blk(r); chk("cbc_enc_b1", r, C1);
      send_words(P, 0, 3, 0); recv_blk(r); chk("cbc_enc_b2", r, C2);
      // CBC decrypt round trip
      cfg_dec = 1; load_iv(IVA);
      send_words(C1, 0, 3, 0); recv_blk(r); chk("cbc_dec_b1", r, P);
      chk("core_dec", core_dec, 1);
      send_words(C2, 0, 3, 0); recv_blk(r); chk("cbc_dec_b2", r, P);
      // iv_load while busy is ignored
      cfg_dec = 0; load_iv('0);
      send_words(P, 0, 1, 0); load_iv(IVA); send_words(P, 2, 3, 0);
      recv_blk(r); chk("iv_load_busy_ignored", r, ECBP);

      // Backpressure in EMIT
      cfg_cbc = 0;
      send_words(P, 0, 3, 0);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); t++; end
      chk("bp_out_valid", out_valid, 1);
      d0 = 128'(out_data); s0 = start_cnt; stable = 1;
      repeat (50) begin
         @(negedge clk);
         if (!out_valid || 128'(out_data) != d0 || in_ready) stable = 0;
      end
      chk("bp_stable", stable, 1);
      chk("bp_no_extra_start", start_cnt, s0);
      recv_blk(r); chk("bp_data", r, ECBP);

      // Reset mid-block discards partial words
      send_words({4{32'h99999999}}, 0, 1, 0);
      @(negedge clk); rst = 1;
      #1 chk("midrst_busy", busy, 0);
      @(negedge clk); rst = 0;
      send_words(P, 0, 3, 0); recv_blk(r); chk("after_reset_block", r, ECBP);

      // Timeout: core never answers
      core_en = 0;
      send_words(P, 0, 3, 0);
      t = 0;
      while (!err_timeout && t < 1200) begin @(negedge clk); t++; end
      chk("timeout_err", err_timeout, 1);
      chk("timeout_cycles_ok", (t >= 1024 && t <= 1026), 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_in_ready", in_ready, 1);
      load_iv('0);
      chk("iv_load_clears_err", err_timeout, 0);
      core_en = 1;
      send_words(P, 0, 3, 0); recv_blk(r); chk("after_timeout_block", r, ECBP);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
